// File: rtl/pe_array_pkg.sv
// Shared constants, drain FSM state type and the saturating add used by the
// output-stationary PE array.
package pe_array_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DW_IN  = 16;
  localparam int DEF_DW_OUT = 32;

  // Working width of the saturation helpers; accumulators up to SAT_W-2 bits fit.
  localparam int SAT_W = 64;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} drain_state_e;

  function automatic logic signed [SAT_W-1:0] sat_hi(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_lo(input int width);
    return -sat_hi(width) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      width
  );
    logic signed [SAT_W-1:0] sum;
    sum = a + b;
    if (sum > sat_hi(width)) return sat_hi(width);
    if (sum < sat_lo(width)) return sat_lo(width);
    return sum;
  endfunction

  function automatic logic sat_ovf(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      width
  );
    logic signed [SAT_W-1:0] sum;
    sum = a + b;
    return (sum > sat_hi(width)) || (sum < sat_lo(width));
  endfunction

endpackage

// File: rtl/pe_array_os_pe.sv
// One output-stationary PE: forwarding registers, valid-qualified signed
// saturating MAC and a shift port used to drain the accumulator row.
module pe_os_sat
  import pe_array_pkg::*;
#(
  parameter int DW_IN  = DEF_DW_IN,
  parameter int DW_OUT = DEF_DW_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain,
  input  logic              clear,
  input  logic [DW_IN-1:0]  act,
  input  logic              act_vld,
  input  logic [DW_IN-1:0]  wgt,
  input  logic              wgt_vld,
  output logic [DW_IN-1:0]  act_fwd,
  output logic              act_fwd_vld,
  output logic [DW_IN-1:0]  wgt_fwd,
  output logic              wgt_fwd_vld,
  input  logic [DW_OUT-1:0] acc_prev,
  output logic [DW_OUT-1:0] acc,
  output logic              ovf
);

  logic                    fire;
  logic signed [2*DW_IN-1:0] prod;
  logic signed [SAT_W-1:0]   acc_ext;
  logic signed [SAT_W-1:0]   prod_ext;

  assign fire     = act_vld & wgt_vld & ~drain;
  assign prod     = $signed(act) * $signed(wgt);
  assign acc_ext  = SAT_W'($signed(acc));
  assign prod_ext = SAT_W'(prod);

  // Draining takes priority: the accumulator only shifts, and clear/MAC wait for IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_fwd     <= '0;
      act_fwd_vld <= 1'b0;
      wgt_fwd     <= '0;
      wgt_fwd_vld <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
    end else begin
      act_fwd_vld <= act_vld;
      wgt_fwd_vld <= wgt_vld;
      if (act_vld) act_fwd <= act;
      if (wgt_vld) wgt_fwd <= wgt;
      if (drain) begin
        acc <= acc_prev;
      end else if (clear) begin
        acc <= fire ? DW_OUT'(prod) : '0;
        ovf <= 1'b0;
      end else if (fire) begin
        acc <= DW_OUT'(sat_add(acc_ext, prod_ext, DW_OUT));
        ovf <= ovf | sat_ovf(acc_ext, prod_ext, DW_OUT);
      end
    end
  end

endmodule

// File: rtl/pe_array_os.sv
// ROWS x COLS output-stationary systolic array with edge pass-through and an
// FSM-controlled drain that shifts results out one column per cycle.
module pe_array_os
  import pe_array_pkg::*;
#(
  parameter  int ROWS           = DEF_ROWS,
  parameter  int COLS           = DEF_COLS,
  parameter  int DATA_WIDTH_IN  = DEF_DW_IN,
  parameter  int DATA_WIDTH_OUT = DEF_DW_OUT,
  localparam int CNT_W          = $clog2(COLS) + 1
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clear_i,
  input  logic [ROWS*DATA_WIDTH_IN-1:0]  act_i,
  input  logic [ROWS-1:0]                act_vld_i,
  input  logic [COLS*DATA_WIDTH_IN-1:0]  wgt_i,
  input  logic [COLS-1:0]                wgt_vld_i,
  output logic [ROWS*DATA_WIDTH_IN-1:0]  act_o,
  output logic [ROWS-1:0]                act_vld_o,
  output logic [COLS*DATA_WIDTH_IN-1:0]  wgt_o,
  output logic [COLS-1:0]                wgt_vld_o,
  input  logic                           drain_i,
  output logic                           busy_o,
  output logic [ROWS*DATA_WIDTH_OUT-1:0] res_o,
  output logic                           res_vld_o,
  output logic [CNT_W-1:0]               res_col_o,
  output logic                           ovf_o
);

  localparam int DW_IN  = DATA_WIDTH_IN;
  localparam int DW_OUT = DATA_WIDTH_OUT;

  drain_state_e     state;
  drain_state_e     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             draining;
  logic             last_shift;

  logic [ROWS-1:0][COLS:0][DW_IN-1:0]  act_h;
  logic [ROWS-1:0][COLS:0]             act_vld_h;
  logic [ROWS:0][COLS-1:0][DW_IN-1:0]  wgt_v;
  logic [ROWS:0][COLS-1:0]             wgt_vld_v;
  logic [ROWS-1:0][COLS:0][DW_OUT-1:0] acc_h;
  logic [ROWS-1:0][COLS-1:0]           ovf_pe;

  assign draining   = (state == DRAIN);
  assign last_shift = (cnt == CNT_W'(COLS - 1));
  assign busy_o     = draining;
  assign ovf_o      = |ovf_pe;

  // Column 0 of every accumulator chain shifts in zeros, so a full drain empties the array.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_edge
    assign act_h[r][0]                 = act_i[r*DW_IN +: DW_IN];
    assign act_vld_h[r][0]             = act_vld_i[r];
    assign act_o[r*DW_IN +: DW_IN]     = act_h[r][COLS];
    assign act_vld_o[r]                = act_vld_h[r][COLS];
    assign acc_h[r][0]                 = '0;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_edge
    assign wgt_v[0][c]                 = wgt_i[c*DW_IN +: DW_IN];
    assign wgt_vld_v[0][c]             = wgt_vld_i[c];
    assign wgt_o[c*DW_IN +: DW_IN]     = wgt_v[ROWS][c];
    assign wgt_vld_o[c]                = wgt_vld_v[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe_os_sat #(
        .DW_IN  (DW_IN),
        .DW_OUT (DW_OUT)
      ) u_pe (
        .clk         (clk_i),
        .rst_n       (rstn_i),
        .drain       (draining),
        .clear       (clear_i),
        .act         (act_h[r][c]),
        .act_vld     (act_vld_h[r][c]),
        .wgt         (wgt_v[r][c]),
        .wgt_vld     (wgt_vld_v[r][c]),
        .act_fwd     (act_h[r][c+1]),
        .act_fwd_vld (act_vld_h[r][c+1]),
        .wgt_fwd     (wgt_v[r+1][c]),
        .wgt_fwd_vld (wgt_vld_v[r+1][c]),
        .acc_prev    (acc_h[r][c]),
        .acc         (acc_h[r][c+1]),
        .ovf         (ovf_pe[r][c])
      );
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drain_i) state_nxt = DRAIN;
      DRAIN:   if (last_shift) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The rightmost column leaves the array each drain cycle, highest column index first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt       <= '0;
      res_o     <= '0;
      res_vld_o <= 1'b0;
      res_col_o <= '0;
    end else begin
      res_vld_o <= draining;
      if (draining) begin
        cnt       <= cnt + 1'b1;
        res_col_o <= CNT_W'(COLS - 1) - cnt;
        for (int r = 0; r < ROWS; r++) begin
          res_o[r*DW_OUT +: DW_OUT] <= acc_h[r][COLS];
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_os.sv
// Directed bench for pe_array_os: a 1x1 instance for MAC/saturation/clear
// and a 2x2 instance for matmul, drain interlocks and reset mid-drain.
module tb_pe_array_os;

  logic clk;
  logic rst_n;

  logic [7:0]  a1, w1, ao1, wo1;
  logic        av1, wv1, clr1, drn1, aov1, wov1, busy1, rv1, ovf1;
  logic [15:0] res1;
  logic [0:0]  rc1;

  logic [15:0] a2, w2, ao2, wo2;
  logic [1:0]  av2, wv2, aov2, wov2, rc2;
  logic        clr2, drn2, busy2, rv2, ovf2;
  logic [31:0] res2;

  int assertCount;
  int failCount;

  // Skewed 2x2 matmul stimulus: row r enters at cycle k+r, column c at cycle k+c.
  logic [7:0] a_t  [6][2] = '{'{8'd1, 8'd0}, '{8'd2, 8'd3}, '{8'd0, 8'd4},
                              '{8'd0, 8'd0}, '{8'd0, 8'd0}, '{8'd0, 8'd0}};
  logic [7:0] w_t  [6][2] = '{'{8'd5, 8'd0}, '{8'd7, 8'd6}, '{8'd0, 8'd8},
                              '{8'd0, 8'd0}, '{8'd0, 8'd0}, '{8'd0, 8'd0}};
  logic [1:0] av_t [6]    = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
  logic [1:0] wv_t [6]    = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};

  pe_array_os #(
    .ROWS(1), .COLS(1), .DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(16)
  ) u_dut1 (
    .clk_i(clk), .rstn_i(rst_n), .clear_i(clr1),
    .act_i(a1), .act_vld_i(av1), .wgt_i(w1), .wgt_vld_i(wv1),
    .act_o(ao1), .act_vld_o(aov1), .wgt_o(wo1), .wgt_vld_o(wov1),
    .drain_i(drn1), .busy_o(busy1), .res_o(res1), .res_vld_o(rv1),
    .res_col_o(rc1), .ovf_o(ovf1)
  );

  pe_array_os #(
    .ROWS(2), .COLS(2), .DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(16)
  ) u_dut2 (
    .clk_i(clk), .rstn_i(rst_n), .clear_i(clr2),
    .act_i(a2), .act_vld_i(av2), .wgt_i(w2), .wgt_vld_i(wv2),
    .act_o(ao2), .act_vld_o(aov2), .wgt_o(wo2), .wgt_vld_o(wov2),
    .drain_i(drn2), .busy_o(busy2), .res_o(res2), .res_vld_o(rv2),
    .res_col_o(rc2), .ovf_o(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] w, input logic v,
                               input logic clr, input logic drn);
    @(negedge clk);
    a1 = a; w1 = w; av1 = v; wv1 = v; clr1 = clr; drn1 = drn;
  endtask

  task automatic applyStimulusArray(input logic [15:0] a, input logic [1:0] av,
                                    input logic [15:0] w, input logic [1:0] wv,
                                    input logic clr, input logic drn);
    @(negedge clk);
    a2 = a; av2 = av; w2 = w; wv2 = wv; clr2 = clr; drn2 = drn;
  endtask

  task automatic drainSingle(input logic [15:0] exp, input string tag);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_busy"}, 64'(busy1), 64'd1);
    checkOutput({tag, "_vld_early"}, 64'(rv1), 64'd0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_vld"}, 64'(rv1), 64'd1);
    checkOutput({tag, "_res"}, 64'(res1), 64'(exp));
    checkOutput({tag, "_col"}, 64'(rc1), 64'd0);
    checkOutput({tag, "_busy_end"}, 64'(busy1), 64'd0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_vld_off"}, 64'(rv1), 64'd0);
    checkOutput({tag, "_res_hold"}, 64'(res1), 64'(exp));
  endtask

  task automatic drainArray(input logic [15:0] c1r0, input logic [15:0] c1r1,
                            input logic [15:0] c0r0, input logic [15:0] c0r1,
                            input string tag);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b1);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput({tag, "_busy0"}, 64'(busy2), 64'd1);
    checkOutput({tag, "_vld_early"}, 64'(rv2), 64'd0);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput({tag, "_b1_vld"}, 64'(rv2), 64'd1);
    checkOutput({tag, "_b1_col"}, 64'(rc2), 64'd1);
    checkOutput({tag, "_b1_r0"}, 64'(res2[15:0]), 64'(c1r0));
    checkOutput({tag, "_b1_r1"}, 64'(res2[31:16]), 64'(c1r1));
    checkOutput({tag, "_busy1"}, 64'(busy2), 64'd1);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput({tag, "_b2_vld"}, 64'(rv2), 64'd1);
    checkOutput({tag, "_b2_col"}, 64'(rc2), 64'd0);
    checkOutput({tag, "_b2_r0"}, 64'(res2[15:0]), 64'(c0r0));
    checkOutput({tag, "_b2_r1"}, 64'(res2[31:16]), 64'(c0r1));
    checkOutput({tag, "_busy2"}, 64'(busy2), 64'd0);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput({tag, "_vld_off"}, 64'(rv2), 64'd0);
  endtask

  // Edge outputs of the 2x2 array lag the inputs by two clock edges.
  task automatic loadMatmul();
    for (int j = 0; j < 6; j++) begin
      applyStimulusArray({a_t[j][1], a_t[j][0]}, av_t[j], {w_t[j][1], w_t[j][0]}, wv_t[j],
                         1'b0, 1'b0);
      if (j >= 2) begin
        checkOutput($sformatf("fwd_act_vld_j%0d", j), 64'(aov2), 64'(av_t[j-2]));
        checkOutput($sformatf("fwd_wgt_vld_j%0d", j), 64'(wov2), 64'(wv_t[j-2]));
        for (int r = 0; r < 2; r++) begin
          if (av_t[j-2][r])
            checkOutput($sformatf("fwd_act_r%0d_j%0d", r, j), 64'(ao2[r*8 +: 8]),
                        64'(a_t[j-2][r]));
          if (wv_t[j-2][r])
            checkOutput($sformatf("fwd_wgt_c%0d_j%0d", r, j), 64'(wo2[r*8 +: 8]),
                        64'(w_t[j-2][r]));
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n = 1'b0;
    a1 = '0; w1 = '0; av1 = 1'b0; wv1 = 1'b0; clr1 = 1'b0; drn1 = 1'b0;
    a2 = '0; w2 = '0; av2 = '0;   wv2 = '0;   clr2 = 1'b0; drn2 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy1", 64'(busy1), 64'd0);
    checkOutput("rst_vld1",  64'(rv1),   64'd0);
    checkOutput("rst_res1",  64'(res1),  64'd0);
    checkOutput("rst_ovf1",  64'(ovf1),  64'd0);
    checkOutput("rst_busy2", 64'(busy2), 64'd0);
    checkOutput("rst_vld2",  64'(rv2),   64'd0);
    checkOutput("rst_res2",  64'(res2),  64'd0);
    checkOutput("rst_aov2",  64'(aov2),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single PE: 0*1+1*2+2*3+3*4");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'(i), 8'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        checkOutput($sformatf("pe1_act_o_%0d", i), 64'(ao1), 64'(i - 1));
        checkOutput($sformatf("pe1_wgt_o_%0d", i), 64'(wo1), 64'(i));
        checkOutput($sformatf("pe1_act_vld_o_%0d", i), 64'(aov1), 64'd1);
      end
    end
    drainSingle(16'd20, "seq");
    checkOutput("seq_ovf", 64'(ovf1), 64'd0);

    $display("[TB] positive saturation");
    repeat (3) applyStimulus(8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_pos_ovf", 64'(ovf1), 64'd1);
    drainSingle(16'h7fff, "sat_pos");
    checkOutput("sat_pos_ovf_kept", 64'(ovf1), 64'd1);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_ovf", 64'(ovf1), 64'd0);

    $display("[TB] negative saturation");
    repeat (3) applyStimulus(8'h80, 8'd127, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_neg_ovf", 64'(ovf1), 64'd1);
    drainSingle(16'h8000, "sat_neg");

    $display("[TB] clear colliding with a fire");
    for (int i = 0; i < 4; i++) applyStimulus(8'(i), 8'(i + 1), 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd3, 8'd4, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("collide_ovf", 64'(ovf1), 64'd0);
    drainSingle(16'd12, "collide");

    $display("[TB] 2x2 matmul");
    loadMatmul();
    drainArray(16'd22, 16'd50, 16'd19, 16'd43, "mm");

    $display("[TB] drain interlocks");
    loadMatmul();
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b1);
    applyStimulusArray(16'h0101, 2'b11, 16'h0101, 2'b11, 1'b0, 1'b0);
    checkOutput("lock_busy0", 64'(busy2), 64'd1);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b1, 1'b1);
    checkOutput("lock_b1_col", 64'(rc2), 64'd1);
    checkOutput("lock_b1_res", 64'(res2), 64'({16'd50, 16'd22}));
    checkOutput("lock_busy1", 64'(busy2), 64'd1);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput("lock_b2_vld", 64'(rv2), 64'd1);
    checkOutput("lock_b2_col", 64'(rc2), 64'd0);
    checkOutput("lock_b2_res", 64'(res2), 64'({16'd43, 16'd19}));
    checkOutput("lock_busy2", 64'(busy2), 64'd0);
    checkOutput("lock_fwd_act_vld", 64'(aov2), 64'd3);
    checkOutput("lock_fwd_act", 64'(ao2), 64'h0101);
    checkOutput("lock_fwd_wgt", 64'(wo2), 64'h0101);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput("lock_busy3", 64'(busy2), 64'd0);
    checkOutput("lock_vld_off", 64'(rv2), 64'd0);
    drainArray(16'd0, 16'd0, 16'd0, 16'd0, "zero");

    $display("[TB] reset during drain");
    loadMatmul();
    repeat (3) applyStimulusArray(16'h007f, 2'b01, 16'h007f, 2'b01, 1'b0, 1'b0);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput("mid_ovf_set", 64'(ovf2), 64'd1);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b1);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput("mid_b1_vld", 64'(rv2), 64'd1);
    checkOutput("mid_b1_res", 64'(res2), 64'({16'd50, 16'd22}));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 64'(busy2), 64'd0);
    checkOutput("mid_rst_vld",  64'(rv2),   64'd0);
    checkOutput("mid_rst_ovf",  64'(ovf2),  64'd0);
    checkOutput("mid_rst_res",  64'(res2),  64'd0);
    checkOutput("mid_rst_col",  64'(rc2),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulusArray(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
    checkOutput("post_rst_busy", 64'(busy2), 64'd0);
    drainArray(16'd0, 16'd0, 16'd0, 16'd0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
